// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, models instruction-memory wait states, and holds an IF/ID register with valid/ready.
// Optional perf counters (FetchCount, SquashCount) are built when IFETCH_PERF_COUNTERS_EN is defined.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [63:0] InstrAddr,
    input  logic [31:0] InstrData,
    input  logic        BranchTaken,
    input  logic [63:0] BranchTarget,
    output logic        IfValid,
    input  logic        IfReady,
    output logic [31:0] IfInstr,
    output logic [63:0] IfPC
`ifdef IFETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] SquashCount
`endif
);

    localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAIT_CYCLES);
    localparam logic [63:0] PC_INIT = {RESET_PC[63:2], 2'b00};

    // Wait counter never goes below zero.
    function automatic logic [WCNT_W-1:0] dec_sat(input logic [WCNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    logic [63:0]       pc_q, pc_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [63:0]       ifpc_q, ifpc_d;
    logic              xfer;
    logic              unused_target_lsbs;

    assign unused_target_lsbs = ^BranchTarget[1:0];
    assign xfer = valid_q && IfReady;

    always_comb begin
        pc_d    = pc_q;
        wcnt_d  = wcnt_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        if (BranchTaken) begin
            // Redirect discards the held word; a same-edge handoff already happened.
            pc_d    = {BranchTarget[63:2], 2'b00};
            valid_d = 1'b0;
            wcnt_d  = WCNT_INIT;
        end else if (wcnt_q != '0) begin
            wcnt_d = dec_sat(wcnt_q);
            if (xfer) valid_d = 1'b0;
        end else if (!valid_q || IfReady) begin
            instr_d = InstrData;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 64'd4;
            wcnt_d  = WCNT_INIT;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q    <= PC_INIT;
            wcnt_q  <= WCNT_INIT;
            valid_q <= 1'b0;
            instr_q <= '0;
            ifpc_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            wcnt_q  <= wcnt_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
        end
    end

    assign InstrAddr = pc_q;
    assign IfValid   = valid_q;
    assign IfInstr   = instr_q;
    assign IfPC      = ifpc_q;

`ifdef IFETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] squash_cnt_q, squash_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + {31'd0, xfer};
        squash_cnt_d = squash_cnt_q + {31'd0, (BranchTaken && valid_q && !IfReady)};
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign FetchCount  = fetch_cnt_q;
    assign SquashCount = squash_cnt_q;
`endif

endmodule
